// File: rtl/pfu_measrcv_if.sv
// ============================================================================
// Module      : pfu_measrcv_if
// Description : Bundle for the measurement-return collector: job start,
//               per-qubit result beats, raster position and logical result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OPCODE_BW
  `define OPCODE_BW 6
`endif
`ifndef UCADDR_BW
  `define UCADDR_BW 4
`endif
`ifndef QBADDR_BW
  `define QBADDR_BW 2
`endif
`ifndef LQI_OPCODE
  `define LQI_OPCODE 6'h01
`endif
`ifndef LQM_X_OPCODE
  `define LQM_X_OPCODE 6'h02
`endif
`ifndef LQM_Y_OPCODE
  `define LQM_Y_OPCODE 6'h03
`endif
`ifndef LQM_Z_OPCODE
  `define LQM_Z_OPCODE 6'h04
`endif
`ifndef MEAS_INTMD_OPCODE
  `define MEAS_INTMD_OPCODE 6'h05
`endif

interface pfu_measrcv_if #(
  parameter int PCHIDX_BW = 6,
  parameter int CNT_BW    = 5
);
  // job start
  logic                   start_valid;
  logic                   start_ready;
  logic [`OPCODE_BW-1:0]  start_opcode;
  logic [PCHIDX_BW-1:0]   start_pchidx;
  // result beats from the qubit plane
  logic                   meas_valid;
  logic                   meas_ready;
  logic                   meas_bit;
  logic                   meas_mask;
  logic                   meas_pf;
  // raster position of the next expected beat
  logic [`UCADDR_BW-1:0]  cur_ucrow;
  logic [`UCADDR_BW-1:0]  cur_uccol;
  logic [`QBADDR_BW-1:0]  cur_qbidx;
  // logical outcome
  logic                   result_valid;
  logic                   result_ready;
  logic                   result_bit;
  logic [PCHIDX_BW-1:0]   result_pchidx;
  logic [`OPCODE_BW-1:0]  result_opcode;
  logic [CNT_BW-1:0]      result_nmask;
  logic                   result_err;

  // upstream side: issues jobs, streams beats, consumes results
  modport master (
    output start_valid, start_opcode, start_pchidx,
    output meas_valid, meas_bit, meas_mask, meas_pf,
    output result_ready,
    input  start_ready, meas_ready,
    input  cur_ucrow, cur_uccol, cur_qbidx,
    input  result_valid, result_bit, result_pchidx, result_opcode,
    input  result_nmask, result_err
  );

  // collector side
  modport slave (
    input  start_valid, start_opcode, start_pchidx,
    input  meas_valid, meas_bit, meas_mask, meas_pf,
    input  result_ready,
    output start_ready, meas_ready,
    output cur_ucrow, cur_uccol, cur_qbidx,
    output result_valid, result_bit, result_pchidx, result_opcode,
    output result_nmask, result_err
  );
endinterface

`default_nettype wire

// File: rtl/pfu_measrcv.sv
// ============================================================================
// Module      : pfu_measrcv
// Description : Measurement-return collector. Walks the (ucrow, uccol, qbidx)
//               raster of a patch, XOR-accumulates masked, frame-corrected
//               result bits into one logical outcome and hands it upstream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OPCODE_BW
  `define OPCODE_BW 6
`endif
`ifndef UCADDR_BW
  `define UCADDR_BW 4
`endif
`ifndef QBADDR_BW
  `define QBADDR_BW 2
`endif
`ifndef LQI_OPCODE
  `define LQI_OPCODE 6'h01
`endif
`ifndef LQM_X_OPCODE
  `define LQM_X_OPCODE 6'h02
`endif
`ifndef LQM_Y_OPCODE
  `define LQM_Y_OPCODE 6'h03
`endif
`ifndef LQM_Z_OPCODE
  `define LQM_Z_OPCODE 6'h04
`endif
`ifndef MEAS_INTMD_OPCODE
  `define MEAS_INTMD_OPCODE 6'h05
`endif

module pfu_measrcv #(
  parameter int NUM_UCROW = 2,
  parameter int NUM_UCCOL = 2,
  parameter int PCHIDX_BW = 6
) (
  input  logic          clk,
  input  logic          rst,
  pfu_measrcv_if.slave  bus
);

  localparam int c_total  = NUM_UCROW * NUM_UCCOL * 4;
  localparam int c_cnt_bw = $clog2(c_total + 1);
  localparam logic [c_cnt_bw-1:0] c_last   = c_cnt_bw'(c_total - 1);
  localparam logic [c_cnt_bw-1:0] c_uccols = c_cnt_bw'(NUM_UCCOL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_cnt_bw-1:0]    r_cnt;
  logic [c_cnt_bw-1:0]    r_nmask;
  logic                   r_parity;
  logic                   r_err;
  logic [PCHIDX_BW-1:0]   r_pchidx;
  logic [`OPCODE_BW-1:0]  r_opcode;

  logic                   w_start_ready;
  logic                   w_meas_ready;
  logic                   w_result_valid;
  logic                   w_start_fire;
  logic                   w_beat;
  logic                   w_op_valid;
  logic [c_cnt_bw-1:0]    w_unit;

  // Only the measurement family of opcodes collects beats; anything else
  // is reported back as an error without touching the qubit stream.
  assign w_op_valid = (bus.start_opcode == `LQM_X_OPCODE) ||
                      (bus.start_opcode == `LQM_Y_OPCODE) ||
                      (bus.start_opcode == `LQM_Z_OPCODE) ||
                      (bus.start_opcode == `MEAS_INTMD_OPCODE);

  assign w_start_fire = bus.start_valid & w_start_ready;
  assign w_beat       = bus.meas_valid & w_meas_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake decodes; all depend on state only
  always_comb begin
    w_next         = r_state;
    w_start_ready  = 1'b0;
    w_meas_ready   = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start_ready = 1'b1;
        if (bus.start_valid) w_next = w_op_valid ? S_COLLECT : S_DONE;
      end
      S_COLLECT: begin
        w_meas_ready = 1'b1;
        if (w_beat && (r_cnt == c_last)) w_next = S_DONE;
      end
      S_DONE: begin
        w_result_valid = 1'b1;
        if (bus.result_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job latch, beat counter and masked parity accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_nmask  <= '0;
      r_parity <= 1'b0;
      r_err    <= 1'b0;
      r_pchidx <= '0;
      r_opcode <= '0;
    end else if (w_start_fire) begin
      r_opcode <= bus.start_opcode;
      r_pchidx <= bus.start_pchidx;
      r_cnt    <= '0;
      r_nmask  <= '0;
      r_parity <= 1'b0;
      r_err    <= ~w_op_valid;
    end else if (w_beat) begin
      r_cnt <= r_cnt + c_cnt_bw'(1);
      if (bus.meas_mask) begin
        r_parity <= r_parity ^ bus.meas_bit ^ bus.meas_pf;
        r_nmask  <= r_nmask + c_cnt_bw'(1);
      end
    end
  end

  // Raster position: qbidx is the fastest index, then column, then row.
  assign w_unit = r_cnt >> 2;

  // Position decode, forced to zero whenever no beats are being collected
  always_comb begin
    bus.cur_qbidx = '0;
    bus.cur_uccol = '0;
    bus.cur_ucrow = '0;
    if (r_state == S_COLLECT) begin
      bus.cur_qbidx = r_cnt[1:0];
      bus.cur_uccol = `UCADDR_BW'(w_unit % c_uccols);
      bus.cur_ucrow = `UCADDR_BW'(w_unit / c_uccols);
    end
  end

  // rst gates start_ready so no job is offered acceptance during reset.
  assign bus.start_ready   = w_start_ready & ~rst;
  assign bus.meas_ready    = w_meas_ready;
  assign bus.result_valid  = w_result_valid;
  assign bus.result_bit    = r_parity;
  assign bus.result_pchidx = r_pchidx;
  assign bus.result_opcode = r_opcode;
  assign bus.result_nmask  = r_nmask;
  assign bus.result_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pfu_measrcv.sv
// ============================================================================
// Module      : tb_pfu_measrcv
// Description : Scoreboard bench for pfu_measrcv. The driver pushes the
//               expected outcome of each job; a monitor pops and compares on
//               every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OPCODE_BW
  `define OPCODE_BW 6
`endif
`ifndef UCADDR_BW
  `define UCADDR_BW 4
`endif
`ifndef QBADDR_BW
  `define QBADDR_BW 2
`endif
`ifndef LQI_OPCODE
  `define LQI_OPCODE 6'h01
`endif
`ifndef LQM_X_OPCODE
  `define LQM_X_OPCODE 6'h02
`endif
`ifndef LQM_Y_OPCODE
  `define LQM_Y_OPCODE 6'h03
`endif
`ifndef LQM_Z_OPCODE
  `define LQM_Z_OPCODE 6'h04
`endif
`ifndef MEAS_INTMD_OPCODE
  `define MEAS_INTMD_OPCODE 6'h05
`endif

module tb_pfu_measrcv;

  logic clk;
  logic rst;

  pfu_measrcv_if #(.PCHIDX_BW(6), .CNT_BW(5)) bus ();

  pfu_measrcv #(
    .NUM_UCROW (2),
    .NUM_UCCOL (2),
    .PCHIDX_BW (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic                  bitv;
    logic [4:0]            nmask;
    logic                  err;
    logic [5:0]            pch;
    logic [`OPCODE_BW-1:0] op;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 2 units after the falling edge, i.e. while the driver's
  // inputs and the DUT outputs are both settled ahead of the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got result with empty scoreboard, expected none");
        end else begin
          e = q.pop_front();
          chk("result_bit",    32'(bus.result_bit),    32'(e.bitv));
          chk("result_nmask",  32'(bus.result_nmask),  32'(e.nmask));
          chk("result_err",    32'(bus.result_err),    32'(e.err));
          chk("result_pchidx", 32'(bus.result_pchidx), 32'(e.pch));
          chk("result_opcode", 32'(bus.result_opcode), 32'(e.op));
        end
      end
    end
  end

  // Runs one job; entered and left on a falling edge.
  task automatic run_job(input logic [`OPCODE_BW-1:0] op, input logic [5:0] pch,
                         input logic [15:0] bits, input logic [15:0] mask,
                         input logic [15:0] pf, input logic ebit, input int enmask,
                         input logic eerr, input bit gaps, input int hold,
                         input int abort_at);
    exp_t e;
    int   k;
    k = 0;
    while (bus.start_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("start_ready_wait", 32'(bus.start_ready), 32'd1);
    bus.start_valid  = 1'b1;
    bus.start_opcode = op;
    bus.start_pchidx = pch;
    if (abort_at < 0) begin
      e.bitv  = ebit;
      e.nmask = 5'(enmask);
      e.err   = eerr;
      e.pch   = pch;
      e.op    = op;
      q.push_back(e);
    end
    @(negedge clk);
    bus.start_valid = 1'b0;
    if (eerr) begin
      chk("err_result_valid_next", 32'(bus.result_valid), 32'd1);
      chk("err_meas_ready",        32'(bus.meas_ready),   32'd0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (gaps) begin
          bus.meas_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if (i == abort_at) begin
          #2 rst = 1'b1;
          #1;
          chk("abort_start_ready",  32'(bus.start_ready),   32'd0);
          chk("abort_meas_ready",   32'(bus.meas_ready),    32'd0);
          chk("abort_result_valid", 32'(bus.result_valid),  32'd0);
          chk("abort_cur_qbidx",    32'(bus.cur_qbidx),     32'd0);
          chk("abort_result_bit",   32'(bus.result_bit),    32'd0);
          chk("abort_result_nmask", 32'(bus.result_nmask),  32'd0);
          chk("abort_result_pch",   32'(bus.result_pchidx), 32'd0);
          chk("abort_result_op",    32'(bus.result_opcode), 32'd0);
          bus.meas_valid = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        chk("cur_qbidx",    32'(bus.cur_qbidx),    32'(i % 4));
        chk("cur_uccol",    32'(bus.cur_uccol),    32'((i / 4) % 2));
        chk("cur_ucrow",    32'(bus.cur_ucrow),    32'((i / 4) / 2));
        chk("meas_ready",   32'(bus.meas_ready),   32'd1);
        chk("result_early", 32'(bus.result_valid), 32'd0);
        bus.meas_valid = 1'b1;
        bus.meas_bit   = bits[i];
        bus.meas_mask  = mask[i];
        bus.meas_pf    = pf[i];
        @(negedge clk);
      end
      bus.meas_valid = 1'b0;
      chk("result_valid_after_last", 32'(bus.result_valid), 32'd1);
    end
    // Stray beats offered while DONE must be ignored on error jobs.
    bus.meas_valid = eerr;
    bus.meas_bit   = 1'b1;
    bus.meas_mask  = 1'b1;
    bus.meas_pf    = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_result_valid", 32'(bus.result_valid), 32'd1);
      chk("hold_start_ready",  32'(bus.start_ready),  32'd0);
      chk("hold_meas_ready",   32'(bus.meas_ready),   32'd0);
      chk("hold_result_bit",   32'(bus.result_bit),   32'(ebit));
      chk("hold_result_nmask", 32'(bus.result_nmask), 32'(enmask));
      @(negedge clk);
    end
    bus.meas_valid   = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("start_ready_after_hs",  32'(bus.start_ready),  32'd1);
    chk("result_valid_after_hs", 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.start_valid  = 1'b0;
    bus.start_opcode = '0;
    bus.start_pchidx = '0;
    bus.meas_valid   = 1'b0;
    bus.meas_bit     = 1'b0;
    bus.meas_mask    = 1'b0;
    bus.meas_pf      = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start_ready_forced", 32'(bus.start_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_start_ready",  32'(bus.start_ready),   32'd1);
    chk("reset_meas_ready",   32'(bus.meas_ready),    32'd0);
    chk("reset_result_valid", 32'(bus.result_valid),  32'd0);
    chk("reset_cur_ucrow",    32'(bus.cur_ucrow),     32'd0);
    chk("reset_cur_uccol",    32'(bus.cur_uccol),     32'd0);
    chk("reset_cur_qbidx",    32'(bus.cur_qbidx),     32'd0);
    chk("reset_result_bit",   32'(bus.result_bit),    32'd0);
    chk("reset_result_nmask", 32'(bus.result_nmask),  32'd0);
    chk("reset_result_err",   32'(bus.result_err),    32'd0);
    chk("reset_result_pch",   32'(bus.result_pchidx), 32'd0);
    chk("reset_result_op",    32'(bus.result_opcode), 32'd0);

    //       op                  pch    bits      mask      pf       bit  nm  err gap hold abort
    // ones on beats 0,3,7 -> parity 1
    run_job(`LQM_Z_OPCODE,      6'd5,  16'h0089, 16'hFFFF, 16'h0000, 1'b1, 16, 1'b0, 0, 0, -1);
    // frame flip on beat 3 cancels its one -> parity 0
    run_job(`LQM_Z_OPCODE,      6'd5,  16'h0089, 16'hFFFF, 16'h0008, 1'b0, 16, 1'b0, 0, 0, -1);
    // beat 3 unmasked -> remaining ones on 0,7 -> parity 0, 15 masked
    run_job(`LQM_Z_OPCODE,      6'd5,  16'h0089, 16'hFFF7, 16'h0008, 1'b0, 15, 1'b0, 0, 0, -1);
    // (A5C3 ^ 0110) & 0F0F = 0403 -> three ones -> parity 1, 8 masked; with gaps
    run_job(`LQM_Y_OPCODE,      6'd33, 16'hA5C3, 16'h0F0F, 16'h0110, 1'b1,  8, 1'b0, 1, 0, -1);
    // non-measurement opcode: immediate error result, stray beats ignored
    run_job(`LQI_OPCODE,        6'd7,  16'h0000, 16'h0000, 16'h0000, 1'b0,  0, 1'b1, 0, 3, -1);
    // 10 cycles of backpressure, then a back-to-back LQM_X job
    run_job(`MEAS_INTMD_OPCODE, 6'd12, 16'h8001, 16'hFFFF, 16'h0000, 1'b0, 16, 1'b0, 0, 10, -1);
    run_job(`LQM_X_OPCODE,      6'd63, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 16, 1'b0, 0, 0, -1);
    // abort at beat 9 after nine ones, then a clean all-zero job
    run_job(`LQM_Z_OPCODE,      6'd9,  16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16, 1'b0, 0, 0, 9);
    run_job(`LQM_Z_OPCODE,      6'd10, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16, 1'b0, 0, 0, -1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pfu_measrcv.md
# pfu_measrcv

Measurement-return collector for the Pauli-frame unit: the receive side of the per-qubit codeword path. After a measurement codeword sweep, the qubit plane streams back one result bit per physical qubit of a patch. This block walks the same (ucrow, uccol, qbidx) raster that codeword generation uses and XOR-accumulates the masked, frame-corrected bits into one logical outcome per patch. It returns that outcome upstream over a valid/ready handshake.

## Interface
- NUM_UCROW, default 2, unit-cell rows per patch.
- NUM_UCCOL, default 2, unit-cell columns per patch.
- PCHIDX_BW, default 6, patch index width.
- Derived: TOTAL = NUM_UCROW*NUM_UCCOL*4 beats per patch; CNT_BW = clog2(TOTAL+1).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  new measurement job offered.
- start_ready  out  1  block can accept a job.
- start_opcode  in  `OPCODE_BW  opcode of the job.
- start_pchidx  in  PCHIDX_BW  patch index of the job.
- meas_valid  in  1  result beat offered.
- meas_ready  out  1  block accepts beats.
- meas_bit  in  1  raw physical measurement bit.
- meas_mask  in  1  beat contributes to the logical outcome.
- meas_pf  in  1  Pauli-frame flip for this qubit.
- cur_ucrow  out  `UCADDR_BW  row of the beat expected next.
- cur_uccol  out  `UCADDR_BW  column of the beat expected next.
- cur_qbidx  out  `QBADDR_BW  qubit index of the beat expected next.
- result_valid  out  1  logical outcome available.
- result_ready  in  1  consumer takes the outcome.
- result_bit  out  1  accumulated parity.
- result_pchidx  out  PCHIDX_BW  latched patch index.
- result_opcode  out  `OPCODE_BW  latched opcode.
- result_nmask  out  CNT_BW  number of masked beats seen.
- result_err  out  1  job had a non-measurement opcode.

## Operation
- FSM states: IDLE, COLLECT, DONE. Reset state is IDLE.
- IDLE:
  - start_ready = 1 (forced 0 while rst is high).
  - On start_valid, latch start_opcode and start_pchidx, and clear parity, beat counter and nmask.
  - Opcode is `LQM_X_OPCODE, `LQM_Y_OPCODE, `LQM_Z_OPCODE or `MEAS_INTMD_OPCODE: go to COLLECT with err = 0.
  - Any other opcode: go straight to DONE with err = 1, parity 0 and nmask 0. No beats are consumed.
- COLLECT:
  - meas_ready = 1.
  - Each accepted beat (meas_valid & meas_ready) increments cnt.
  - When meas_mask = 1, parity ^= meas_bit ^ meas_pf and nmask += 1. Unmasked beats only advance the count.
  - The accepted beat with cnt == TOTAL-1 moves the FSM to DONE.
- DONE:
  - result_valid = 1, and all result_* outputs are held stable.
  - result_valid & result_ready returns the FSM to IDLE.
- Raster decode of cnt: qbidx = cnt[1:0] (fastest), uccol = (cnt>>2) % NUM_UCCOL, ucrow = (cnt>>2) / NUM_UCCOL. The cur_* outputs are registered-state decodes and are valid in every state; they read 0 outside COLLECT.
- meas_ready is 0 in IDLE and DONE. Beats offered there are not consumed and have no effect.
- start_ready is 0 in COLLECT and DONE, so jobs never overlap.

## Timing
- Reset (asynchronous) values: state IDLE, cnt 0, parity 0, nmask 0, err 0, result_pchidx 0, result_opcode 0. Outputs meas_ready 0, result_valid 0, cur_* 0.
- Asserting rst mid-job aborts the job with no result.
- Job accepted at edge T: meas_ready is high in cycle T+1.
- Final beat accepted at edge L: result_valid is high in cycle L+1.
- Minimum job latency: TOTAL+1 cycles from start acceptance to result_valid.
- Invalid opcode accepted at edge T: result_valid is high in cycle T+1.
- Result handshake at edge R: start_ready is high in cycle R+1. There is no same-cycle bypass from DONE to a new job.
- Stalls: meas_valid gaps and result_ready backpressure are unlimited. State and outputs hold across them.
- All outputs come from registers or from decodes of state only. No input-to-output combinational path except rst → start_ready.

## Test plan
- LQM_Z on pchidx 5, 16 beats, meas_mask on all beats, meas_bit = 1 on beats 0, 3 and 7, meas_pf = 0 → result_bit 1, nmask 16, err 0, result_pchidx 5.
- Same job with meas_pf = 1 on beat 3 only → result_bit 0. Beat 3 then has meas_mask cleared → unmasked, result_bit 0 and nmask 15.
- Raster check with random meas_valid gaps → cur_(ucrow, uccol, qbidx) steps (0,0,0), (0,0,1) … (0,1,3), (1,0,0) … (1,1,3). result_valid rises exactly one cycle after the 16th accepted beat.
- start_opcode = `LQI_OPCODE → result_valid next cycle with err 1, result_bit 0, nmask 0. meas_ready never asserts.
- Hold result_ready low for 10 cycles → result_* stable and start_ready 0. After the handshake, start_ready is 1 the next cycle, and a back-to-back LQM_X job completes correctly.
- Assert rst at beat 9 of a job → all outputs return to reset values immediately. The next job's parity is unaffected by the aborted job.
